mux_arbitro_rr: RTL and testbench
=================================

MUX_ARBITRO_RR -- requirements
Module: mux_arbitro_rr

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel.
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SELW, default $clog2(N), channel-index width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel data-valid.
REQ-008 in_ready  output  N  per-channel accept; combinational.
REQ-009 mode  input  1  0 = fixed select via sel, 1 = round-robin.
REQ-010 sel  input  SELW  channel index used in fixed mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_ch  output  SELW  registered index of the channel held in out_data.
REQ-013 out_valid  output  1  output register holds data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 load = !out_valid || out_ready; transfer on channel i when in_valid[i] && in_ready[i].
REQ-016 Fixed mode: grant = sel, grant_valid = in_valid[sel]; sel >= N gives no grant.
REQ-017 RR mode: grant = first i with in_valid[i], scanning ptr, ptr+1, ... modulo N; grant_valid = |in_valid.
REQ-018 in_ready[i] = load && grant_valid && (grant == i); at most one bit set per cycle.
REQ-019 On transfer, next cycle: out_data = in_data[grant], out_ch = grant, out_valid = 1; latency exactly 1 cycle.
REQ-020 If load and no grant, out_valid clears next cycle; out_data/out_ch hold last values.
REQ-021 While out_valid && !out_ready, out_data, out_ch and out_valid hold; all in_ready = 0.
REQ-022 Simultaneous drain and accept (out_ready=1, grant_valid=1) yields back-to-back transfers, full throughput.
REQ-023 ptr advances to (grant+1) mod N only on an RR-mode transfer; wraps from N-1 to 0; unchanged in fixed mode.
REQ-024 mode or sel changes take effect on the same cycle's grant; held output is unaffected.

Reset
REQ-025 Asserting rst clears out_valid, out_data, out_ch and ptr to 0 immediately, independent of clk.
REQ-026 A transfer in flight during reset is dropped; in_ready is 0 while rst is high.

Configuration
REQ-027 With MUX_ARBITRO_RR_PARITY_EN defined: extra output out_par (1 bit), registered with out_data, = XOR of out_data bits (even parity); reset value 0.
REQ-028 Without MUX_ARBITRO_RR_PARITY_EN: port out_par absent; all other behaviour identical.

Structure
REQ-029 Package mux_pkg holds mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
REQ-030 Sub-module rr_arbiter (parameter N; inputs req, ptr; outputs grant, grant_valid), purely combinational, instantiated once.

Verification (N=4, WIDTH=8)
REQ-031 Fixed mode, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_data=8'hA5, out_ch=2, out_valid=1; ptr stays 0.
REQ-032 RR mode, all in_valid=1 for 6 cycles, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 (wrap).
REQ-033 out_valid=1, out_ready=0 for 3 cycles, in_valid=4'b1111 -> out_data stable, in_ready=4'b0000 every cycle.
REQ-034 RR mode, ptr=3, in_valid=4'b0011 -> grant 0, then ptr=1, next grant 1.
REQ-035 rst pulsed between clock edges while out_valid=1 -> out_valid=0, out_data=8'h00, ptr=0 before next edge.
REQ-036 With MUX_ARBITRO_RR_PARITY_EN, transfer of 8'h07 -> out_par=1; of 8'h03 -> out_par=0.

Source files
------------

// File: rtl/mux_arbitro_rr_pkg.sv
// Shared constants for the mux_arbitro_rr channel multiplexer.
// The mode encodings are used by the top level and by the testbench.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/mux_arbitro_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// It scans req starting at ptr and wraps modulo N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    logic w_found;

    // The first requester at or after ptr wins; later matches are ignored.
    always_comb begin
        grant       = '0;
        grant_valid = |req;
        w_found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[(int'(ptr) + k) % N]) begin
                grant   = SELW'((int'(ptr) + k) % N);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbitro_rr.sv
// N-to-1 data multiplexer with one output register and fixed or round-robin selection.
// Defining MUX_ARBITRO_RR_PARITY_EN adds an even-parity output, out_par, that is registered with out_data.
module mux_arbitro_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_ARBITRO_RR_PARITY_EN
    ,
    output logic               out_par
`endif
);

    logic [SELW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_outData;
    logic [SELW-1:0]  r_outCh;
    logic             r_outValid;

    logic [SELW-1:0]  w_rrGrant;
    logic             w_rrValid;
    logic [SELW-1:0]  w_grant;
    logic             w_grantValid;
    logic             w_load;
    logic             w_transfer;
    logic [WIDTH-1:0] w_selData;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (r_ptr),
        .grant       (w_rrGrant),
        .grant_valid (w_rrValid)
    );

    // An out-of-range sel in fixed mode produces no grant.
    always_comb begin
        w_grant      = '0;
        w_grantValid = 1'b0;
        if (mode == MODE_RR) begin
            w_grant      = w_rrGrant;
            w_grantValid = w_rrValid;
        end else if (int'(sel) < N) begin
            w_grant      = sel;
            w_grantValid = in_valid[sel];
        end
    end

    assign w_load     = !r_outValid || out_ready;
    assign w_transfer = w_load && w_grantValid;
    assign w_selData  = in_data[int'(w_grant)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (!rst && w_transfer) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    // The pointer moves only on round-robin transfers, so fixed-mode traffic leaves the rotation untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_outValid <= 1'b0;
        end else if (w_load) begin
            if (w_grantValid) begin
                r_outData  <= w_selData;
                r_outCh    <= w_grant;
                r_outValid <= 1'b1;
                if (mode == MODE_RR) begin
                    r_ptr <= (int'(w_grant) == N-1) ? '0 : w_grant + SELW'(1);
                end
            end else begin
                r_outValid <= 1'b0;
            end
        end
    end

`ifdef MUX_ARBITRO_RR_PARITY_EN
    logic r_outPar;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outPar <= 1'b0;
        end else if (w_transfer) begin
            r_outPar <= ^w_selData;
        end
    end

    assign out_par = r_outPar;
`endif

    assign out_data  = r_outData;
    assign out_ch    = r_outCh;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// Scoreboard testbench for mux_arbitro_rr with N=4 and WIDTH=8.
// Define MUX_ARBITRO_RR_PARITY_EN to also check the parity output.
module tb_mux_arbitro_rr;
    import mux_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic        mode = MODE_FIXED;
    logic [1:0]  sel = '0;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef MUX_ARBITRO_RR_PARITY_EN
    logic        out_par;
`endif

    int checks   = 0;
    int failures = 0;

    logic [9:0] expQ[$];
    logic [7:0] mData;
    logic [1:0] mCh;
    logic       mOutValid;
    logic [1:0] mPtr;

    mux_arbitro_rr #(.WIDTH(8), .N(4), .SELW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_ARBITRO_RR_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        mData     = '0;
        mCh       = '0;
        mOutValid = 1'b0;
        mPtr      = '0;
    endtask

    // Drive one cycle of inputs. At the negedge, check the outputs against the reference model,
    // predict this cycle's grant, then step past the rising edge.
    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                                 input logic ordy, input logic [31:0] d);
        logic [1:0] g;
        logic [1:0] idx;
        logic       gv;
        logic       ld;
        logic [3:0] expReady;
        logic [9:0] e;
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        in_data   = d;
        @(negedge clk);
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            {mCh, mData} = e;
        end
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mOutValid});
        checkOutput("out_data", {24'd0, out_data}, {24'd0, mData});
        checkOutput("out_ch", {30'd0, out_ch}, {30'd0, mCh});
`ifdef MUX_ARBITRO_RR_PARITY_EN
        checkOutput("out_par", {31'd0, out_par}, {31'd0, ^mData});
`endif
        ld = !mOutValid || ordy;
        g  = '0;
        gv = 1'b0;
        if (m == MODE_FIXED) begin
            g  = s;
            gv = v[s];
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = mPtr + 2'(k);
                if (!gv && v[idx]) begin
                    g  = idx;
                    gv = 1'b1;
                end
            end
        end
        expReady = (ld && gv) ? (4'b0001 << g) : 4'b0000;
        checkOutput("in_ready", {28'd0, in_ready}, {28'd0, expReady});
        if (ld) begin
            if (gv) begin
                expQ.push_back({g, d[int'(g)*8 +: 8]});
                mOutValid = 1'b1;
                if (m == MODE_RR) mPtr = g + 2'd1;
            end else begin
                mOutValid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetModel();
        mode      = MODE_RR;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #3;
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, out_data}, 32'd0);
        checkOutput("rst_ch", {30'd0, out_ch}, 32'd0);
        checkOutput("rst_ready", {28'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fixed select of channel 2
        applyStimulus(MODE_FIXED, 2'd2, 4'b0100, 1'b1, 32'h11A52233);
        checkOutput("fixed_data", {24'd0, out_data}, 32'h0000_00A5);
        checkOutput("fixed_ch", {30'd0, out_ch}, 32'd2);
        checkOutput("fixed_valid", {31'd0, out_valid}, 32'd1);

        // Round-robin rotation with wrap; the fixed transfer must not have moved the pointer
        for (int k = 0; k < 6; k++) begin
            applyStimulus(MODE_RR, 2'd0, 4'b1111, 1'b1, 32'h44332211);
            checkOutput("rr_seq", {30'd0, out_ch}, 32'(k % 4));
        end

        // Back-pressure holds the output and blocks every channel
        for (int k = 0; k < 3; k++) begin
            applyStimulus(MODE_RR, 2'd0, 4'b1111, 1'b0, $urandom);
            checkOutput("stall_data", {24'd0, out_data}, 32'h0000_0022);
            checkOutput("stall_ready", {28'd0, in_ready}, 32'd0);
        end
        applyStimulus(MODE_RR, 2'd0, 4'b0000, 1'b1, 32'h0);

        // Walk the pointer to 3, then check the wrap to 0 and the following grant of 1
        applyStimulus(MODE_RR, 2'd0, 4'b0100, 1'b1, 32'h0055_0000);
        checkOutput("ptr_walk", {30'd0, out_ch}, 32'd2);
        applyStimulus(MODE_RR, 2'd0, 4'b0011, 1'b1, 32'h0000_BB77);
        checkOutput("wrap_grant0", {30'd0, out_ch}, 32'd0);
        applyStimulus(MODE_RR, 2'd0, 4'b0011, 1'b1, 32'h0000_BB77);
        checkOutput("wrap_grant1", {30'd0, out_ch}, 32'd1);

        // Asynchronous reset pulse between edges
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("arst_data", {24'd0, out_data}, 32'd0);
        checkOutput("arst_ready", {28'd0, in_ready}, 32'd0);
        #1 rst = 1'b0;
        resetModel();
        applyStimulus(MODE_RR, 2'd0, 4'b1111, 1'b1, 32'hDDCCBBAA);
        checkOutput("arst_ptr", {30'd0, out_ch}, 32'd0);

`ifdef MUX_ARBITRO_RR_PARITY_EN
        applyStimulus(MODE_FIXED, 2'd0, 4'b0001, 1'b1, 32'h0000_0007);
        checkOutput("par_07", {31'd0, out_par}, 32'd1);
        applyStimulus(MODE_FIXED, 2'd0, 4'b0001, 1'b1, 32'h0000_0003);
        checkOutput("par_03", {31'd0, out_par}, 32'd0);
`endif

        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), $urandom);
        end
        applyStimulus(MODE_RR, 2'd0, 4'b0000, 1'b1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
